// File: rtl/hdc_spatial_bundler.sv
// hdc_spatial_bundler: per-modality majority bundling of projection rows fetched for nonzero channels
// Ports: Clk_CI/Reset_RI clock and async active-low reset; ValidIn_SI/ReadyOut_SO/Raw_DI sample input;
// MemReq_SO/MemAddr_DO/MemReady_SI/MemValid_SI/MemRow_DI projection memory port;
// ValidOut_SO/ReadyIn_SI/HypervectorOut_DO/ModalityOut_DO/LastOut_SO bundled output.
module hdc_spatial_bundler #(
  parameter int DIM = 2048,
  parameter int MODALITIES = 3,
  parameter int CH_PER_MOD = 4,
  parameter int CH_WIDTH = 8,
  parameter int TIE_MODE = 0,
  localparam int C = MODALITIES * CH_PER_MOD,
  localparam int AW = $clog2(2 * C),
  localparam int MW = (MODALITIES > 1) ? $clog2(MODALITIES) : 1,
  localparam int NW = $clog2(CH_PER_MOD + 1)
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic                  ValidIn_SI,
  output logic                  ReadyOut_SO,
  input  logic [0:C*CH_WIDTH-1] Raw_DI,
  output logic                  MemReq_SO,
  output logic [AW-1:0]         MemAddr_DO,
  input  logic                  MemReady_SI,
  input  logic                  MemValid_SI,
  input  logic [0:DIM-1]        MemRow_DI,
  output logic                  ValidOut_SO,
  input  logic                  ReadyIn_SI,
  output logic [0:DIM-1]        HypervectorOut_DO,
  output logic [MW-1:0]         ModalityOut_DO,
  output logic                  LastOut_SO
);
  localparam int CW = (CH_PER_MOD > 1) ? $clog2(CH_PER_MOD) : 1;
  localparam logic TIE_BIT = TIE_MODE != 0;
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, FETCH = 3'd2, WAIT = 3'd3, OUT = 3'd4;
  logic [2:0] state;
  logic ready_q;
  logic [0:C*CH_WIDTH-1] raw_q;
  logic [MW-1:0] m;
  logic [CW-1:0] c;
  logic [NW-1:0] n, n_nxt;
  logic [NW-1:0] cnt [DIM];
  logic [NW-1:0] cnt_nxt [DIM];
  logic [0:DIM-1] maj;
  logic [AW-1:0] ch, addr_q;
  logic [CH_WIDTH-1:0] v;
  logic acc, last_ch, last_mod, to_out, clr;
  assign ReadyOut_SO = ready_q;
  assign MemReq_SO = state == FETCH;
  assign MemAddr_DO = addr_q;
  assign ValidOut_SO = state == OUT;
  always_comb begin
    ch = AW'(m) * AW'(CH_PER_MOD) + AW'(c);
    v = raw_q[int'(ch) * CH_WIDTH +: CH_WIDTH];
    last_ch = c == CW'(CH_PER_MOD - 1);
    last_mod = m == MW'(MODALITIES - 1);
    acc = state == WAIT && MemValid_SI;
    to_out = last_ch && ((state == SCAN && v == '0) || acc);
    clr = (state == IDLE && ValidIn_SI && ready_q) || (state == OUT && ReadyIn_SI && !last_mod);
  end
  // Majority is taken over the counts including a row arriving this cycle,
  // so the result can be registered on the same edge that enters OUT.
  always_comb begin
    n_nxt = n + NW'(acc);
    for (int i = 0; i < DIM; i++) begin
      cnt_nxt[i] = cnt[i] + NW'(acc & MemRow_DI[i]);
      maj[i] = (n_nxt == '0) ? 1'b0 :
               ({cnt_nxt[i], 1'b0} > {1'b0, n_nxt}) ? 1'b1 :
               ({cnt_nxt[i], 1'b0} == {1'b0, n_nxt}) ? TIE_BIT : 1'b0;
    end
  end
  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) begin
      cnt <= '{default: '0};
      n <= '0;
    end else if (clr) begin
      cnt <= '{default: '0};
      n <= '0;
    end else if (acc) begin
      cnt <= cnt_nxt;
      n <= n_nxt;
    end
  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) begin
      state <= IDLE;
      ready_q <= 1'b0;
      raw_q <= '0;
      m <= '0;
      c <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE:
          if (ValidIn_SI && ready_q) begin
            raw_q <= Raw_DI;
            m <= '0;
            c <= '0;
            ready_q <= 1'b0;
            state <= SCAN;
          end else ready_q <= 1'b1;
        SCAN:
          if (v != '0) begin
            addr_q <= (ch << 1) | AW'(v[CH_WIDTH-1]);
            state <= FETCH;
          end else if (last_ch) state <= OUT;
          else c <= c + 1'b1;
        FETCH: if (MemReady_SI) state <= WAIT;
        WAIT:
          if (acc) begin
            state <= last_ch ? OUT : SCAN;
            c <= last_ch ? c : c + 1'b1;
          end
        OUT:
          if (ReadyIn_SI) begin
            ready_q <= last_mod;
            state <= last_mod ? IDLE : SCAN;
            m <= last_mod ? m : m + 1'b1;
            c <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) begin
      HypervectorOut_DO <= '0;
      ModalityOut_DO <= '0;
      LastOut_SO <= 1'b0;
    end else if (to_out) begin
      HypervectorOut_DO <= maj;
      ModalityOut_DO <= m;
      LastOut_SO <= last_mod;
    end
endmodule

// File: tb/tb_hdc_spatial_bundler.sv
// tb_hdc_spatial_bundler: directed checks of the spatial bundler with both tie modes side by side
module tb_hdc_spatial_bundler;
  localparam logic [0:23] RAW_A = 24'h1230F2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, valid_in, ready_in, mem_rdy, inj;
  logic rsp_v = 1'b0;
  logic [0:7] rsp_row = '0;
  logic [0:23] raw;
  logic mem_valid;
  logic [0:7] mem_row;
  assign mem_valid = rsp_v | inj;
  assign mem_row = inj ? 8'hFF : rsp_row;
  logic rdy0, req0, vout0, last0, rdy1, req1, vout1, last1;
  logic [3:0] addr0, addr1;
  logic [0:7] hv0, hv1;
  logic [0:0] mod0, mod1;
  int errors = 0, checks = 0;
  hdc_spatial_bundler #(.DIM(8), .MODALITIES(2), .CH_PER_MOD(3), .CH_WIDTH(4), .TIE_MODE(0)) dut0 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(valid_in), .ReadyOut_SO(rdy0), .Raw_DI(raw),
    .MemReq_SO(req0), .MemAddr_DO(addr0), .MemReady_SI(mem_rdy), .MemValid_SI(mem_valid),
    .MemRow_DI(mem_row), .ValidOut_SO(vout0), .ReadyIn_SI(ready_in), .HypervectorOut_DO(hv0),
    .ModalityOut_DO(mod0), .LastOut_SO(last0));
  hdc_spatial_bundler #(.DIM(8), .MODALITIES(2), .CH_PER_MOD(3), .CH_WIDTH(4), .TIE_MODE(1)) dut1 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(valid_in), .ReadyOut_SO(rdy1), .Raw_DI(raw),
    .MemReq_SO(req1), .MemAddr_DO(addr1), .MemReady_SI(mem_rdy), .MemValid_SI(mem_valid),
    .MemRow_DI(mem_row), .ValidOut_SO(vout1), .ReadyIn_SI(ready_in), .HypervectorOut_DO(hv1),
    .ModalityOut_DO(mod1), .LastOut_SO(last1));
  function automatic logic [0:7] tbl(input logic [3:0] a);
    case (a)
      4'd0: return 8'hC0;
      4'd2: return 8'hA0;
      4'd4: return 8'h90;
      4'd9: return 8'hF0;
      4'd10: return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction
  logic hs;
  logic [3:0] ha;
  logic [3:0] alog[$];
  // Ideal memory: a row answers one cycle after each request handshake.
  always @(posedge clk) begin
    hs = req0 & mem_rdy;
    ha = addr0;
    if (hs) alog.push_back(ha);
    #1;
    rsp_v = hs;
    rsp_row = tbl(ha);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [0:23] r);
    raw = r;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask
  task automatic wait_out(input int maxc, output int cyc);
    cyc = 0;
    while (!vout0 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic expect_mod(input string tag, input int ecyc, input logic [7:0] e0, input logic [7:0] e1,
                            input logic em, input logic el, input int stall);
    int cyc, st;
    wait_out(60, cyc);
    chk({tag, "_valid"}, vout0, 1);
    if (ecyc >= 0) chk({tag, "_latency"}, cyc, ecyc);
    chk({tag, "_hv_tie0"}, hv0, e0);
    chk({tag, "_hv_tie1"}, hv1, e1);
    chk({tag, "_modality"}, mod0, em);
    chk({tag, "_last"}, last0, el);
    chk({tag, "_busy"}, rdy0, 0);
    if (stall > 0) begin
      st = 0;
      repeat (stall) begin
        @(negedge clk);
        st += int'(vout0 === 1'b1 && hv0 === e0 && mod0 === em && last0 === el && req0 === 1'b0);
      end
      chk({tag, "_stall_hold"}, st, stall);
    end
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask
  task automatic check_log(input string tag);
    logic [3:0] exp_a [5] = '{4'd0, 4'd2, 4'd4, 4'd9, 4'd10};
    chk({tag, "_nreq"}, alog.size(), 5);
    for (int i = 0; i < 5 && i < alog.size(); i++) chk({tag, "_addr"}, alog[i], exp_a[i]);
  endtask
  initial begin
    int reqs, hold;
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; mem_rdy = 1'b1; inj = 1'b0; raw = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_req", req0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_valid", vout0, 0);
    chk("rst_hv", hv0, 0);
    chk("rst_mod", mod0, 0);
    chk("rst_last", last0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    reqs = 0;
    repeat (4) begin
      @(negedge clk);
      reqs += int'(req0);
    end
    chk("idle_ready", rdy0, 1);
    chk("idle_noreq", reqs, 0);
    alog.delete();
    send(RAW_A);
    expect_mod("s2", 9, 8'h80, 8'h80, 1'b0, 1'b0, 0);
    expect_mod("s3", 7, 8'h30, 8'hFC, 1'b1, 1'b1, 0);
    chk("s3_ready_again", rdy0, 1);
    check_log("s23");
    alog.delete();
    send(24'h000000);
    expect_mod("s4a", 3, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    expect_mod("s4b", 3, 8'h00, 8'h00, 1'b1, 1'b1, 0);
    chk("s4_nreq", alog.size(), 0);
    alog.delete();
    mem_rdy = 1'b0;
    send(RAW_A);
    @(negedge clk);
    hold = 0;
    repeat (4) begin
      hold += int'(req0 === 1'b1 && addr0 === 4'd0);
      @(negedge clk);
    end
    chk("s5_fetch_hold", hold, 4);
    mem_rdy = 1'b1;
    expect_mod("s5a", -1, 8'h80, 8'h80, 1'b0, 1'b0, 5);
    chk("s5_nreq_m0", alog.size(), 3);
    expect_mod("s5b", 7, 8'h30, 8'hFC, 1'b1, 1'b1, 0);
    check_log("s5");
    send(RAW_A);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", vout0, 0);
    chk("s6_rst_req", req0, 0);
    chk("s6_rst_ready", rdy0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("s6_ready", rdy0, 1);
    chk("s6_idle_valid", vout0, 0);
    alog.delete();
    send(RAW_A);
    expect_mod("s6a", 9, 8'h80, 8'h80, 1'b0, 1'b0, 0);
    expect_mod("s6b", 7, 8'h30, 8'hFC, 1'b1, 1'b1, 0);
    check_log("s6");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
